ring_counter: RTL and testbench
===============================

# ring_counter

Structural one-hot ring counter: a chain of `WIDTH` D flip-flops whose last stage feeds the first. A single `1` circulates through the register, advancing one position per clock. It serves as a phase and sequence generator, e.g. for round-robin strobes and multiplexer selects. It is built as explicit per-bit flip-flop instances, not a behavioural shift statement.

## Interface
- `WIDTH`, default 4: number of stages and the width of `q`; legal values are ≥ 2.
- `clk`, input, 1: rising-edge clock; the only clock.
- `rst_n`, input, 1: reset, synchronous and active-low; sampled on the `clk` rising edge.
- `q`, output, `WIDTH`: counter state, one-hot, taken directly from the flip-flop outputs.

## Operation
- **Structure:**
  - One D flip-flop per bit.
  - The D input of bit `i` is `q[i-1]` for `i` = 1..`WIDTH-1`.
  - The D input of bit 0 is `q[WIDTH-1]` (the wrap-around).
  - No combinational logic sits between the flop outputs and `q`.
- **Reset:** `rst_n`=0 at a rising edge loads `q` = `{WIDTH-1{0},1}`; for `WIDTH`=4 this is 4'b0001.
  - Bit 0's flop resets to 1; all other flops reset to 0.
- **Count:** `rst_n`=1 at a rising edge performs a rotate-left by one.
  - New `q` = `{q[WIDTH-2:0], q[WIDTH-1]}`.
  - For `WIDTH`=4 the sequence is 0001 → 0010 → 0100 → 1000 → 0001, repeating.
- **No hold:** there is no enable. The counter advances on every non-reset edge.
- **Before first reset:** the state is undefined (X in simulation). Users must apply reset before relying on `q`.
- **Illegal states:** any non-one-hot value is illegal, e.g. 0000 or 0011. Behaviour in an illegal state depends on the configuration option below.

## Timing
- Latency: `q` changes only on `clk` rising edges, with clock-to-q delay only.
- Reset takes effect on the first rising edge with `rst_n`=0; asserting `rst_n` between edges has no effect.
- First advance: the first rising edge with `rst_n`=1 after reset produces 0010 (`WIDTH`=4).
- Period: the pattern repeats every `WIDTH` clocks.
- Wrap-around: `q[WIDTH-1]`=1 is followed by `q`=…0001 on the next edge.
- Reset mid-count: `rst_n`=0 at any edge forces …0001 on that edge, regardless of the current position. Reset overrides counting.
- Release: when `rst_n` rises, the next edge with `rst_n`=1 resumes counting from …0001.

## Configuration
- Macro: `RING_COUNTER_SELF_CORRECT_EN`.
- **Defined:**
  - A correction term is added to bit 0's D input.
  - When `q` contains zero or more than one `1`, the next edge with `rst_n`=1 loads …0001.
  - Legal one-hot states still rotate exactly as above.
  - Recovery from any state takes at most 1 clock.
- **Undefined:**
  - The ring is pure rotation with no correction.
  - An illegal state persists and rotates indefinitely; for example, 0011 → 0110 → 1100 → 1001 → 0011, and 0000 stays at 0000.
- Reset behaviour is identical in both builds.

## Test plan
- **Reset and sequence:** hold `rst_n`=0 for 2 edges → `q`=0001. Release and clock 8 edges → 0010, 0100, 1000, 0001, 0010, 0100, 1000, 0001.
- **Reset mid-count:** with `q`=0100, drive `rst_n`=0 for one edge → `q`=0001 on that edge. Release → next edge gives 0010.
- **Reset synchronicity:** pulse `rst_n` low and back high entirely between two rising edges → `q` continues rotating unchanged.
- **Long run:** release reset and run 200 time units at a 10-unit clock period → `q` is one-hot after every edge and equals 0001 every 4th edge.
- **Illegal state, macro defined:** force the flops to 0011, then release the force → next edge `q`=0001. Repeat with 0000 → next edge `q`=0001.
- **Illegal state, macro undefined:** force 0011 → successive edges give 0110, 1100, 1001, 0011. Force 0000 → `q` stays 0000 until reset, after which it is 0001.

Source files
------------

// File: rtl/ring_counter.sv
// One-hot ring counter built from per-bit flop instances.
// Option: RING_COUNTER_SELF_CORRECT_EN adds one-clock recovery from illegal states.
module ring_dff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
  end

endmodule

module ring_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] d;

`ifdef RING_COUNTER_SELF_CORRECT_EN
  logic seen;
  logic multi;
  logic bad;

  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (q[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
  end

  assign bad = ~seen | multi;

  // An illegal state reloads the ring with a single 1 at bit 0
  assign d[0] = q[WIDTH-1] | bad;

  for (genvar i = 1; i < WIDTH; i++) begin : g_d
    assign d[i] = q[i-1] & ~bad;
  end
`else
  assign d[0] = q[WIDTH-1];

  for (genvar i = 1; i < WIDTH; i++) begin : g_d
    assign d[i] = q[i-1];
  end
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ring_dff #(
      .RST_VAL(1'(i == 0))
    ) u_ff (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (d[i]),
      .q    (q[i])
    );
  end

endmodule

// File: tb/tb_ring_counter.sv
// Bench for ring_counter: vector table, hand sequences, random model check.
// Illegal-state expectations follow RING_COUNTER_SELF_CORRECT_EN.
module tb_ring_counter;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] q;

  int total;
  int bad;

  ring_counter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic [W-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, got, exp);
    end
  endtask

  task automatic step(input logic r);
    @(negedge clk);
    rst_n = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v);
    return W'((v << 1) | (v >> (W - 1)));
  endfunction

  function automatic int ones(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(v[i]);
    return n;
  endfunction

  vec_t vt[14];
  int   pos;
  logic [W-1:0] exp_v;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;

    vt[0]  = '{1'b0, 4'b0001};
    vt[1]  = '{1'b0, 4'b0001};
    vt[2]  = '{1'b1, 4'b0010};
    vt[3]  = '{1'b1, 4'b0100};
    vt[4]  = '{1'b1, 4'b1000};
    vt[5]  = '{1'b1, 4'b0001};
    vt[6]  = '{1'b1, 4'b0010};
    vt[7]  = '{1'b1, 4'b0100};
    vt[8]  = '{1'b1, 4'b1000};
    vt[9]  = '{1'b1, 4'b0001};
    vt[10] = '{1'b1, 4'b0010};
    vt[11] = '{1'b1, 4'b0100};
    vt[12] = '{1'b0, 4'b0001};
    vt[13] = '{1'b1, 4'b0010};

    for (int i = 0; i < 14; i++) begin
      step(vt[i].rst_n);
      check($sformatf("vec%0d", i), q, vt[i].exp);
    end

    // reset pulse entirely between edges is ignored
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("async_pulse", q, 4'b0100);

    // long run: one-hot every edge, 0001 every 4th edge
    step(1'b0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1);
      total++;
      if (ones(q) != 1) begin
        bad++;
        $display("FAIL long_onehot%0d: got %b want one-hot", i, q);
      end
      if (i % 4 == 0) check($sformatf("long_wrap%0d", i), q, 4'b0001);
    end

    // random reset pattern against a position model
    step(1'b0);
    pos = 0;
    for (int i = 0; i < 60; i++) begin
      logic r;
      r = 1'($urandom_range(0, 4) != 0);
      step(r);
      pos = r ? (pos + 1) % W : 0;
      exp_v = W'(1) << pos;
      check($sformatf("rand%0d", i), q, exp_v);
    end

    // illegal state 0011
    @(negedge clk);
    rst_n = 1'b1;
    force dut.d = 4'b0011;
    @(posedge clk);
    #1;
    release dut.d;
    check("load_0011", q, 4'b0011);
    exp_v = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
`ifdef RING_COUNTER_SELF_CORRECT_EN
      exp_v = (i == 0) ? 4'b0001 : rotl(exp_v);
`else
      exp_v = rotl(exp_v);
`endif
      check($sformatf("ill3_%0d", i), q, exp_v);
    end

    // illegal state 0000
    @(negedge clk);
    force dut.d = 4'b0000;
    @(posedge clk);
    #1;
    release dut.d;
    check("load_0000", q, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
`ifdef RING_COUNTER_SELF_CORRECT_EN
      exp_v = (i == 0) ? 4'b0001 : rotl(exp_v);
`else
      exp_v = 4'b0000;
`endif
      check($sformatf("ill0_%0d", i), q, exp_v);
    end
    step(1'b0);
    check("ill0_rst", q, 4'b0001);
    step(1'b1);
    check("ill0_rel", q, 4'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
